// File: rtl/sd_phy_cmd_ctrl_if.sv
// Host/wrapper-side signal bundle for the SD command/response controller.
// The slave modport is the controller; the master modport is the host/wrapper side.
interface sd_phy_cmd_ctrl_if #(
    parameter int CMD_W   = 48,
    parameter int RESP_W  = 136,
    parameter int RETRY_W = 2
);
    logic               iStrobe_in;
    logic [CMD_W-1:0]   iCmd;
    logic [1:0]         iResp_type;
    logic               iTransmission_complete;
    logic               iResp_start;
    logic               iReception_complete;
    logic [RESP_W-1:0]  iPad_response;
    logic               iAck_in;
    logic               oReset_wrapper;
    logic               oEnable_PTS_wrapper;
    logic               oEnable_STP_wrapper;
    logic               oPad_stable;
    logic               oPad_enable;
    logic               oLoad_send;
    logic [CMD_W-1:0]   oCmd;
    logic               oStrobe_out;
    logic [RESP_W-1:0]  oResponse;
    logic [1:0]         oStatus;
    logic [RETRY_W-1:0] oRetry_count;
    logic               oBusy;
    logic               oAck_out;

    modport slave (
        input  iStrobe_in, iCmd, iResp_type, iTransmission_complete, iResp_start,
               iReception_complete, iPad_response, iAck_in,
        output oReset_wrapper, oEnable_PTS_wrapper, oEnable_STP_wrapper, oPad_stable,
               oPad_enable, oLoad_send, oCmd, oStrobe_out, oResponse, oStatus,
               oRetry_count, oBusy, oAck_out
    );

    modport master (
        output iStrobe_in, iCmd, iResp_type, iTransmission_complete, iResp_start,
               iReception_complete, iPad_response, iAck_in,
        input  oReset_wrapper, oEnable_PTS_wrapper, oEnable_STP_wrapper, oPad_stable,
               oPad_enable, oLoad_send, oCmd, oStrobe_out, oResponse, oStatus,
               oRetry_count, oBusy, oAck_out
    );
endinterface

// File: rtl/sd_phy_cmd_ctrl.sv
// SD physical-layer command/response controller: sends a command frame, waits for an
// optional short/long response with timeout and bounded retry, holds the result until acked.
module sd_phy_cmd_ctrl #(
    parameter int CMD_W       = 48,
    parameter int RESP_W      = 136,
    parameter int SHORT_W     = 48,
    parameter int TIMEOUT_CYC = 64,
    parameter int MAX_RETRY   = 2,
    parameter int RETRY_W     = 2
) (
    input logic              iClock_SD,
    input logic              iReset,
    sd_phy_cmd_ctrl_if.slave bus
);
    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
    localparam logic [RESP_W-1:0]  SHORT_MASK = RESP_W'({SHORT_W{1'b1}});
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_IDLE  = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
        S_WAIT  = 3'd4,
        S_RECV  = 3'd5,
        S_DONE  = 3'd6,
        S_ACK   = 3'd7
    } state_t;

    typedef struct packed {
        logic reset_wrapper;
        logic en_pts;
        logic en_stp;
        logic pad_stable;
        logic pad_enable;
        logic load_send;
        logic strobe_out;
        logic ack_out;
        logic busy;
    } ctrl_t;

    state_t             state;
    ctrl_t              ctrl;
    logic [CMD_W-1:0]   cmd_lat;
    logic [1:0]         resp_type;
    logic [RESP_W-1:0]  resp_cap;
    logic [1:0]         status;
    logic [RETRY_W-1:0] retry_cnt;
    logic [TMR_W-1:0]   timer;

    // Control outputs registered alongside the state they belong to.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c      = '0;
        c.busy = (s != S_IDLE);
        case (s)
            S_RESET: c.reset_wrapper = 1'b1;
            S_IDLE:  c.reset_wrapper = 1'b1;
            S_LOAD: begin
                c.en_pts     = 1'b1;
                c.pad_stable = 1'b1;
                c.pad_enable = 1'b1;
            end
            S_SEND: begin
                c.en_pts     = 1'b1;
                c.pad_stable = 1'b1;
                c.pad_enable = 1'b1;
                c.load_send  = 1'b1;
            end
            S_WAIT:  c.en_stp     = 1'b1;
            S_RECV:  c.en_stp     = 1'b1;
            S_DONE:  c.strobe_out = 1'b1;
            S_ACK:   c.ack_out    = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [RESP_W-1:0] shape_resp(input logic [RESP_W-1:0] raw,
                                                     input logic [1:0] rtype);
        return (rtype == 2'b01) ? (raw & SHORT_MASK) : raw;
    endfunction

    always_ff @(posedge iClock_SD) begin
        if (iReset) begin
            state     <= S_RESET;
            ctrl      <= '0;
            cmd_lat   <= '0;
            resp_type <= '0;
            resp_cap  <= '0;
            status    <= ST_OK;
            retry_cnt <= '0;
            timer     <= '0;
        end else begin
            ctrl <= ctrl_of(state);
            case (state)
                S_RESET: begin
                    state <= S_IDLE;
                    ctrl  <= ctrl_of(S_IDLE);
                end
                S_IDLE: begin
                    if (bus.iStrobe_in) begin
                        cmd_lat   <= bus.iCmd;
                        resp_type <= bus.iResp_type;
                        retry_cnt <= '0;
                        status    <= ST_OK;
                        resp_cap  <= '0;
                        state     <= S_LOAD;
                        ctrl      <= ctrl_of(S_LOAD);
                    end
                end
                S_LOAD: begin
                    state <= S_SEND;
                    ctrl  <= ctrl_of(S_SEND);
                end
                S_SEND: begin
                    if (bus.iTransmission_complete) begin
                        if (resp_type == 2'b00) begin
                            status <= ST_OK;
                            state  <= S_DONE;
                            ctrl   <= ctrl_of(S_DONE);
                        end else begin
                            timer <= '0;
                            state <= S_WAIT;
                            ctrl  <= ctrl_of(S_WAIT);
                        end
                    end
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    // A start bit on the last timer count still counts as a response.
                    if (bus.iResp_start) begin
                        if (bus.iReception_complete) begin
                            resp_cap <= shape_resp(bus.iPad_response, resp_type);
                            status   <= ST_OK;
                            state    <= S_DONE;
                            ctrl     <= ctrl_of(S_DONE);
                        end else begin
                            state <= S_RECV;
                            ctrl  <= ctrl_of(S_RECV);
                        end
                    end else if (timer == TMR_LAST) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= S_LOAD;
                            ctrl      <= ctrl_of(S_LOAD);
                        end else begin
                            status   <= ST_TIMEOUT;
                            resp_cap <= '0;
                            state    <= S_DONE;
                            ctrl     <= ctrl_of(S_DONE);
                        end
                    end
                end
                S_RECV: begin
                    if (bus.iReception_complete) begin
                        resp_cap <= shape_resp(bus.iPad_response, resp_type);
                        status   <= ST_OK;
                        state    <= S_DONE;
                        ctrl     <= ctrl_of(S_DONE);
                    end
                end
                S_DONE: begin
                    if (bus.iAck_in) begin
                        state <= S_ACK;
                        ctrl  <= ctrl_of(S_ACK);
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                    ctrl  <= ctrl_of(S_IDLE);
                end
                default: begin
                    state <= S_RESET;
                    ctrl  <= ctrl_of(S_RESET);
                end
            endcase
        end
    end

    assign bus.oReset_wrapper      = ctrl.reset_wrapper;
    assign bus.oEnable_PTS_wrapper = ctrl.en_pts;
    assign bus.oEnable_STP_wrapper = ctrl.en_stp;
    assign bus.oPad_stable         = ctrl.pad_stable;
    assign bus.oPad_enable         = ctrl.pad_enable;
    assign bus.oLoad_send          = ctrl.load_send;
    assign bus.oStrobe_out         = ctrl.strobe_out;
    assign bus.oAck_out            = ctrl.ack_out;
    assign bus.oBusy               = ctrl.busy;
    assign bus.oCmd                = cmd_lat;
    assign bus.oResponse           = resp_cap;
    assign bus.oStatus             = status;
    assign bus.oRetry_count        = retry_cnt;
endmodule

// File: tb/tb_sd_phy_cmd_ctrl.sv
// Bench for sd_phy_cmd_ctrl: directed and random commands driven by a reactive wrapper
// model, with results and latency predicted from per-attempt timing plans.
module tb_sd_phy_cmd_ctrl;
    localparam int CMD_W       = 48;
    localparam int RESP_W      = 136;
    localparam int SHORT_W     = 48;
    localparam int TIMEOUT_CYC = 8;
    localparam int MAX_RETRY   = 2;
    localparam int RETRY_W     = 2;
    localparam int NEVER       = 1000;
    localparam int NATT        = MAX_RETRY + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sd_phy_cmd_ctrl_if #(.CMD_W(CMD_W), .RESP_W(RESP_W), .RETRY_W(RETRY_W)) bus ();

    sd_phy_cmd_ctrl #(
        .CMD_W(CMD_W), .RESP_W(RESP_W), .SHORT_W(SHORT_W),
        .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY), .RETRY_W(RETRY_W)
    ) dut (
        .iClock_SD(clk),
        .iReset(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Per-attempt wrapper timing: SEND cycles before tx complete, WAIT cycles before start.
    int tx_d [NATT];
    int st_d [NATT];

    task automatic chk(input string tag, input logic [RESP_W-1:0] obs, input logic [RESP_W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pulses();
        bus.iStrobe_in             = 1'b0;
        bus.iTransmission_complete = 1'b0;
        bus.iResp_start            = 1'b0;
        bus.iReception_complete    = 1'b0;
        bus.iAck_in                = 1'b0;
    endtask

    function automatic logic [RESP_W-1:0] rand_resp();
        logic [159:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return v[RESP_W-1:0];
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, {bus.oReset_wrapper, bus.oEnable_PTS_wrapper, bus.oEnable_STP_wrapper,
                             bus.oPad_stable, bus.oPad_enable, bus.oLoad_send, bus.oStrobe_out,
                             bus.oBusy, bus.oAck_out, bus.oStatus, bus.oRetry_count}, '0);
        chk({tag, "_cmd"}, bus.oCmd, '0);
        chk({tag, "_resp"}, bus.oResponse, '0);
    endtask

    task automatic run_txn(input string tag, input logic [1:0] rtype, input logic [CMD_W-1:0] cmd,
                           input logic [RESP_W-1:0] data, input int rx, input int ackd);
        int exp_att, exp_lat, exp_retry;
        logic [1:0] exp_status;
        logic [RESP_W-1:0] exp_resp;
        logic ok;
        int attempt, ai, phase, scnt, wcnt, rcnt, loads, cyc;
        logic seen;
        logic [63:0] junk;

        // Reference outcome from the attempt plan.
        exp_status = 2'b00;
        exp_resp   = '0;
        exp_retry  = 0;
        if (rtype == 2'b00) begin
            exp_att = 1;
            exp_lat = 1 + tx_d[0];
        end else begin
            ok = 1'b0;
            exp_att = 0;
            exp_lat = 0;
            for (int k = 0; k < NATT && !ok; k++) begin
                exp_att++;
                exp_lat += 1 + tx_d[k];
                if (st_d[k] < TIMEOUT_CYC) begin
                    exp_lat += st_d[k] + 1 + rx;
                    ok = 1'b1;
                end else begin
                    exp_lat += TIMEOUT_CYC;
                end
            end
            exp_retry = exp_att - 1;
            if (ok) exp_resp = (rtype == 2'b01) ? (data & RESP_W'({SHORT_W{1'b1}})) : data;
            else    exp_status = 2'b01;
        end

        @(negedge clk);
        clear_pulses();
        bus.iStrobe_in = 1'b1;
        bus.iCmd       = cmd;
        bus.iResp_type = rtype;
        attempt = -1; phase = 0; scnt = 0; wcnt = 0; rcnt = 0; loads = 0; cyc = 0; seen = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            clear_pulses();
            bus.iPad_response = rand_resp();
            if (bus.oStrobe_out) begin
                seen = 1'b1;
                break;
            end
            cyc++;
            ai = (attempt < 0) ? 0 : ((attempt > MAX_RETRY) ? MAX_RETRY : attempt);
            if (bus.oPad_enable && !bus.oLoad_send) begin
                attempt++;
                loads++;
                phase = 1;
                scnt  = 0;
            end else if (bus.oLoad_send) begin
                scnt++;
                bus.iAck_in = 1'($urandom % 2);
                if (phase == 1 && scnt == tx_d[ai]) begin
                    bus.iTransmission_complete = 1'b1;
                    phase = 2;
                    wcnt  = 0;
                end
            end else if (bus.oEnable_STP_wrapper) begin
                if (phase == 2) begin
                    if (wcnt == st_d[ai]) begin
                        bus.iResp_start = 1'b1;
                        if (rx == 0) begin
                            bus.iReception_complete = 1'b1;
                            bus.iPad_response       = data;
                            phase = 4;
                        end else begin
                            phase = 3;
                            rcnt  = 0;
                        end
                    end
                    wcnt++;
                end else if (phase == 3) begin
                    rcnt++;
                    junk = {$urandom, $urandom};
                    bus.iStrobe_in = 1'b1;
                    bus.iCmd       = junk[CMD_W-1:0];
                    if (rcnt == rx) begin
                        bus.iReception_complete = 1'b1;
                        bus.iPad_response       = data;
                        phase = 4;
                    end
                end
            end
        end

        chk({tag, "_strobe_seen"}, seen, 1'b1);
        chk({tag, "_status"}, bus.oStatus, exp_status);
        chk({tag, "_resp"}, bus.oResponse, exp_resp);
        chk({tag, "_retry"}, bus.oRetry_count, exp_retry);
        chk({tag, "_cmd"}, bus.oCmd, cmd);
        chk({tag, "_sends"}, loads, exp_att);
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_busy"}, bus.oBusy, 1'b1);

        for (int h = 0; h < ackd; h++) begin
            @(negedge clk);
            clear_pulses();
            chk({tag, "_hold_strobe"}, bus.oStrobe_out, 1'b1);
            chk({tag, "_hold_resp"}, bus.oResponse, exp_resp);
            chk({tag, "_hold_status"}, bus.oStatus, exp_status);
        end
        bus.iAck_in = 1'b1;
        @(negedge clk);
        clear_pulses();
        chk({tag, "_ack_pulse"}, {bus.oAck_out, bus.oStrobe_out}, 2'b10);
        @(negedge clk);
        chk({tag, "_ack_end"}, {bus.oAck_out, bus.oBusy, bus.oReset_wrapper}, 3'b001);
    endtask

    initial begin
        logic [RESP_W-1:0] d;
        logic [63:0] c64;
        int rx, ackd;
        logic [1:0] ty;

        clear_pulses();
        bus.iCmd          = '0;
        bus.iResp_type    = 2'b00;
        bus.iPad_response = '0;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("init_rst");
        end
        rst = 1'b0;
        @(negedge clk);
        chk("init_idle", {bus.oReset_wrapper, bus.oBusy}, 2'b10);

        for (int k = 0; k < NATT; k++) begin tx_d[k] = 48; st_d[k] = NEVER; end
        run_txn("none", 2'b00, 48'h40_0000_0000_95, rand_resp(), 0, 2);

        st_d[0] = 5;
        run_txn("short_ones", 2'b01, 48'h51_0000_0000_01, {RESP_W{1'b1}}, 3, 1);

        for (int k = 0; k < NATT; k++) begin tx_d[k] = 4; st_d[k] = NEVER; end
        run_txn("timeout", 2'b01, 48'h4D_0001_0000_7F, rand_resp(), 2, 1);

        st_d[0] = TIMEOUT_CYC - 1;
        run_txn("late_start", 2'b01, 48'h48_0000_01AA_87, rand_resp(), 4, 0);

        d = rand_resp();
        d[7:0] = 8'hA5;
        st_d[0] = 2;
        run_txn("long_hold", 2'b10, 48'h42_0000_0000_4D, d, 6, 20);

        st_d[0] = NEVER; st_d[1] = 3;
        run_txn("type3_retry_fast", 2'b11, 48'h49_0000_0000_1B, rand_resp(), 0, 1);

        // Reset in the middle of a SEND.
        @(negedge clk);
        clear_pulses();
        bus.iStrobe_in = 1'b1;
        bus.iCmd       = 48'h4A_1234_5678_9B;
        bus.iResp_type = 2'b01;
        @(negedge clk);
        clear_pulses();
        @(negedge clk);
        chk("mid_send", bus.oLoad_send, 1'b1);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("mid_rst");
        end
        rst = 1'b0;
        @(negedge clk);
        chk("mid_idle", {bus.oReset_wrapper, bus.oBusy, bus.oStrobe_out, bus.oAck_out}, 4'b1000);
        chk("mid_cmd_clr", bus.oCmd, '0);

        for (int t = 0; t < 25; t++) begin
            ty = 2'($urandom % 4);
            c64 = {$urandom, $urandom};
            for (int k = 0; k < NATT; k++) begin
                tx_d[k] = 1 + int'($urandom % 20);
                st_d[k] = ($urandom % 2 == 0) ? NEVER : int'($urandom % TIMEOUT_CYC);
            end
            rx   = int'($urandom % 7);
            ackd = int'($urandom % 6);
            run_txn("rand", ty, c64[CMD_W-1:0], rand_resp(), rx, ackd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
